lsu_mem_master: RTL
===================

Name: lsu_mem_master

Overview:
- Load/store initiator between the execute stage and the two-port byte-addressed little-endian data RAM.
- Drives the RAM's read-write port:
  - word address;
  - a 32-bit write-data bus;
  - a single write enable with no byte enables.
- Services RV32I LB/LH/LW/LBU/LHU/SB/SH/SW:
  - aligns addresses to words;
  - extracts and extends load lanes;
  - performs read-modify-write for sub-word stores.
- Flags misaligned, illegal or out-of-range accesses.

Parameters:
- MEM_BYTES, 1024, RAM size in bytes; a word access must satisfy aligned_addr + 3 < MEM_BYTES.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, synchronous active-high reset.
- req_valid, input, 1, request present.
- req_ready, output, 1, block can accept a request.
- req_we, input, 1, 1 = store, 0 = load.
- req_funct3, input, 3, RV32I funct3 size/sign code.
- req_addr, input, 32, byte address.
- req_wdata, input, 32, store data, right-justified.
- resp_valid, output, 1, one-cycle completion pulse.
- resp_rdata, output, 32, extended load data; 0 for stores and errors.
- resp_err, output, 1, access rejected; valid only with resp_valid.
- mem_addr, output, 32, RAM port-2 address, always word-aligned (low 2 bits 0).
- mem_wen, output, 1, RAM port-2 write enable.
- mem_wdata, output, 32, RAM port-2 write data.
- mem_rdata, input, 32, RAM port-2 read data; combinational from mem_addr in the same cycle.

Behaviour:
- States: IDLE, LOAD, RMW_RD, WRITE, RESP.
- Reset: state=IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_wen=0, mem_addr=0, mem_wdata=0.
  - Reset mid-operation abandons the operation; no write is issued after the reset edge.
- IDLE:
  - req_ready=1. On req_valid&&req_ready, capture we, funct3, addr, wdata; set off = addr[1:0], waddr = {addr[31:2], 2'b00}.
  - Error when any of:
    - funct3 is 011, 110 or 111;
    - store with funct3[2]=1;
    - half-word with off[0]=1;
    - word with off!=0;
    - waddr+3 >= MEM_BYTES.
  - Error -> RESP with err=1. Otherwise:
    - load -> LOAD;
    - SW -> WRITE;
    - SB/SH -> RMW_RD.
- req_ready=0 in every state except IDLE; requests presented then are ignored, not queued.
- LOAD:
  - mem_addr = waddr; byte = mem_rdata[8*off +: 8]; half = mem_rdata[8*off +: 16].
  - LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
  - Register into resp_rdata -> RESP.
- RMW_RD:
  - mem_addr = waddr; latch merged word = mem_rdata with the selected lane replaced by req_wdata[7:0] (SB) or req_wdata[15:0] (SH).
  - Go to WRITE.
- WRITE:
  - mem_addr = waddr, mem_wen=1, mem_wdata = merged word (SW: req_wdata unchanged).
  - Write commits on this edge -> RESP.
- RESP: resp_valid=1 for exactly one cycle, resp_err as determined -> IDLE.
  - No backpressure on the response.
  - resp_rdata holds its value until the next load completes; it is 0 after a store or an error response.
- mem_wen is 1 only in WRITE; an erroring store never writes.
- mem_addr holds its last value outside LOAD/RMW_RD/WRITE.
- Latency measured from the acceptance edge:
  - load and error: resp_valid in cycle +2;
  - SW: cycle +2;
  - SB/SH: cycle +3.
- Back-to-back throughput: one request per 3 cycles (load/SW) or 4 cycles (SB/SH).

Test Plan:
- RAM[0x10..0x13] = 0x80,0x7F,0x34,0x12 (word 0x12347F80).
  - LB 0x10 -> 0xFFFFFF80; LBU 0x10 -> 0x00000080.
  - LH 0x12 -> 0x00001234; LW 0x10 -> 0x12347F80.
  - Each load has resp_valid 2 cycles after acceptance.
- SB 0x11, wdata=0xAABBCCDD on word 0x12347F80:
  - mem_wen pulses once with mem_addr=0x10 and mem_wdata=0x1234DD80;
  - resp_valid at +3; a following LW 0x10 returns 0x1234DD80.
- SH 0x12, wdata=0x0000BEEF -> RAM word 0xBEEFxxxx with low half preserved.
- SW 0x20, 0xDEADBEEF -> mem_wdata=0xDEADBEEF, mem_addr=0x20; a following LW 0x20 returns 0xDEADBEEF.
- Error cases each give resp_err=1, resp_rdata=0 and mem_wen never asserted:
  - LW 0x11 (misaligned);
  - SH 0x13 (misaligned);
  - funct3=011;
  - SW 0x3FC with MEM_BYTES=1024 succeeds, but SW 0x400 errors.
- Assert rst during the RMW_RD cycle of an SB -> mem_wen stays 0, RAM is unchanged, and outputs return to their reset values next cycle.
- Hold req_valid high continuously -> exactly one acceptance per completed transaction; req_ready=0 while busy.

Source files
------------

// File: rtl/lsu_mem_master.sv
// Load/store initiator for the byte-addressed little-endian data RAM.
// It word-aligns accesses, extends load lanes and merges sub-word stores read-modify-write.
module lsu_mem_master #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;

    state_t      state_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic        err_q;

    logic [31:0] wordAddr;
    logic [1:0]  reqOff;
    logic        reqErr;
    logic [4:0]  laneShift;
    logic [31:0] shifted;
    logic [31:0] loadData;
    logic [31:0] laneMask;
    logic [31:0] mergedWord;

    assign reqOff   = req_addr[1:0];
    assign wordAddr = {req_addr[31:2], 2'b00};

    always_comb begin
        reqErr = 1'b0;
        case (req_funct3)
            3'b011, 3'b110, 3'b111: reqErr = 1'b1;
            default: ;
        endcase
        if (req_we && req_funct3[2]) reqErr = 1'b1;
        if (req_funct3[1:0] == 2'b01 && reqOff[0]) reqErr = 1'b1;
        if (req_funct3[1:0] == 2'b10 && reqOff != 2'b00) reqErr = 1'b1;
        if ({1'b0, wordAddr} + 33'd3 >= 33'(MEM_BYTES)) reqErr = 1'b1;
    end

    // Lane extraction and merge both work on the word shifted by the byte offset.
    assign laneShift  = {off_q, 3'b000};
    assign shifted    = mem_rdata >> laneShift;
    assign laneMask   = (funct3_q[1:0] == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
    assign mergedWord = (mem_rdata & ~(laneMask << laneShift)) | ((wdata_q & laneMask) << laneShift);

    always_comb begin
        loadData = mem_rdata;
        case (funct3_q)
            3'b000:  loadData = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  loadData = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  loadData = {24'h0, shifted[7:0]};
            3'b101:  loadData = {16'h0, shifted[15:0]};
            default: loadData = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            funct3_q   <= 3'b000;
            off_q      <= 2'b00;
            wdata_q    <= 32'h0;
            err_q      <= 1'b0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
            mem_addr   <= 32'h0;
            mem_wen    <= 1'b0;
            mem_wdata  <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        funct3_q  <= req_funct3;
                        off_q     <= reqOff;
                        wdata_q   <= req_wdata;
                        err_q     <= reqErr;
                        req_ready <= 1'b0;
                        // Rejected accesses borrow the LOAD slot so they answer with load latency,
                        // but never put their address on the RAM port.
                        if (reqErr) begin
                            state_q <= LOAD;
                        end else begin
                            mem_addr <= wordAddr;
                            if (!req_we) begin
                                state_q <= LOAD;
                            end else if (req_funct3[1:0] == 2'b10) begin
                                mem_wen   <= 1'b1;
                                mem_wdata <= req_wdata;
                                state_q   <= WRITE;
                            end else begin
                                state_q <= RMW_RD;
                            end
                        end
                    end
                end
                LOAD: begin
                    resp_rdata <= err_q ? 32'h0 : loadData;
                    resp_err   <= err_q;
                    resp_valid <= 1'b1;
                    state_q    <= RESP;
                end
                RMW_RD: begin
                    mem_wdata <= mergedWord;
                    mem_wen   <= 1'b1;
                    state_q   <= WRITE;
                end
                WRITE: begin
                    mem_wen    <= 1'b0;
                    resp_rdata <= 32'h0;
                    resp_err   <= 1'b0;
                    resp_valid <= 1'b1;
                    state_q    <= RESP;
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    req_ready  <= 1'b1;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
